nibble_serial_subtractor: RTL and testbench

NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

---
 rtl/nibble_serial_subtractor.sv | 126 ++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - nibble-serial a - b - bin with carry-lookahead per nibble
// Valid/ready handshake on both sides; one 4-bit nibble is resolved per RUN cycle.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NIB = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic             c_q, c_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [3:0] a_nib, nb_nib, g, p, sum;
  logic [4:0] cy;

  // Subtraction as a + ~b + c, with c = ~borrow; g/p use the inverted subtrahend.
  always_comb begin
    a_nib  = a_q[{idx_q, 2'b00} +: 4];
    nb_nib = ~b_q[{idx_q, 2'b00} +: 4];
    g      = a_nib & nb_nib;
    p      = a_nib | nb_nib;
    cy[0]  = c_q;
    cy[1]  = g[0] | (p[0] & c_q);
    cy[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
    cy[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
    cy[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c_q);
    sum    = a_nib ^ nb_nib ^ cy[3:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    c_d     = c_q;
    idx_d   = idx_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = ~bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        d_d[{idx_q, 2'b00} +: 4] = sum;
        c_d   = cy[4];
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          bout_d  = ~cy[4];
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (d_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (d_d == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - self-checking bench for nibble_serial_subtractor
// Directed and randomized operations compared against an arithmetic reference model.
module tb_nibble_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         bin_i = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] d;
  logic         bout, ovf, zero, out_valid;
  logic         out_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a_i), .b(b_i), .bin(bin_i),
    .in_valid(in_valid), .in_ready(in_ready), .d(d), .bout(bout),
    .ovf(ovf), .zero(zero), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bn;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    logic         z;
  } vec_t;

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bn,
                                output logic [W-1:0] dm, output logic bo, output logic ov,
                                output logic z);
    int r;
    dm = a - b - W'(bn);
    bo = (int'(a) < int'(b) + int'(bn));
    r  = int'($signed(a)) - int'($signed(b)) - int'(bn);
    ov = (r < -32768) || (r > 32767);
    z  = (dm == '0);
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bn);
    @(negedge clk);
    a_i = a; b_i = b; bin_i = bn; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); bin_i = 1'($urandom);
  endtask

  // Operands are scrambled every cycle while the operation is in flight.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      a_i = W'($urandom); b_i = W'($urandom); bin_i = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    checks++;
    if (d !== '0 || bout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: d=%h bout=%b ovf=%b zero=%b expected 0000/0/0/0", d, bout, ovf, zero);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t v[6];
    int cyc;
    v[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
    v[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    v[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    v[3] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    v[4] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    v[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start_op(v[i].a, v[i].b, v[i].bn);
      wait_done(cyc);
      checks++;
      if (cyc !== 4) begin
        failures++;
        $display("FAIL dir_latency[%0d]: cycles=%0d expected 4", i, cyc);
      end
      checks++;
      if (d !== v[i].d || bout !== v[i].bo || ovf !== v[i].ov || zero !== v[i].z) begin
        failures++;
        $display("FAIL dir_result[%0d]: d=%h bout=%b ovf=%b zero=%b expected %h/%b/%b/%b",
                 i, d, bout, ovf, zero, v[i].d, v[i].bo, v[i].ov, v[i].z);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || d !== v[i].d) begin
        failures++;
        $display("FAIL dir_return[%0d]: out_valid=%b in_ready=%b d=%h expected 0/1/%h",
                 i, out_valid, in_ready, d, v[i].d);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, ed;
    logic rbn, eb, eo, ez;
    int cyc, stall;
    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbn = 1'($urandom);
      if (i % 5 == 0) rb = ra;
      model(ra, rb, rbn, ed, eb, eo, ez);
      stall = $urandom_range(0, 2);
      out_ready = (stall == 0);
      start_op(ra, rb, rbn);
      wait_done(cyc);
      checks++;
      if (cyc !== 4 || d !== ed || bout !== eb || ovf !== eo || zero !== ez) begin
        failures++;
        $display("FAIL rand[%0d] %h-%h-%b: cyc=%0d d=%h bout=%b ovf=%b zero=%b expected 4 %h/%b/%b/%b",
                 i, ra, rb, rbn, cyc, d, bout, ovf, zero, ed, eb, eo, ez);
      end
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || d !== ed || bout !== eb || ovf !== eo || zero !== ez) begin
          failures++;
          $display("FAIL rand_stall[%0d]: out_valid=%b d=%h expected 1/%h", i, out_valid, d, ed);
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ed;
    logic eb, eo, ez;
    int cyc;
    model(16'hF0F0, 16'h0F0F, 1'b0, ed, eb, eo, ez);
    out_ready = 1'b0;
    start_op(16'hF0F0, 16'h0F0F, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 4 || d !== 16'hE1E1 || bout !== 1'b0 || ovf !== eo) begin
      failures++;
      $display("FAIL bp_result: cyc=%0d d=%h bout=%b ovf=%b expected 4 e1e1/0/%b", cyc, d, bout, ovf, eo);
    end
    a_i = 16'h0003; b_i = 16'h0001; bin_i = 1'b0; in_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== ed || bout !== eb || ovf !== eo || zero !== ez) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b d=%h expected 1/0/%h", s, out_valid, in_ready, d, ed);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || d !== ed) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b d=%h expected 0/1/%h", out_valid, in_ready, d, ed);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept: in_ready=%b expected 0", in_ready);
    end
    in_valid = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc !== 4 || d !== 16'h0002 || bout !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL bp_next: cyc=%0d d=%h bout=%b expected 4 0002/0", cyc, d, bout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    out_ready = 1'b1;
    start_op(16'h1111, 16'h0222, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || d !== '0 || in_ready !== 1'b1 || bout !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL midrst: out_valid=%b d=%h in_ready=%b bout=%b zero=%b expected 0/0000/1/0/0",
               out_valid, d, in_ready, bout, zero);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_hold: in_ready=%b expected 1", in_ready);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    start_op(16'hFFFF, 16'h0000, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc !== 4 || d !== 16'hFFFE || bout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL postrst: cyc=%0d d=%h bout=%b ovf=%b expected 4 fffe/0/0", cyc, d, bout, ovf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
